// File: rtl/if_stage_pkg.sv
// Shared core defines for the instruction-fetch stage: widths, reset vector,
// NOP encoding, fetch FSM encoding and the IF/ID payload layout.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSN     = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP      = 32'h0000_0004;
  localparam logic [XLEN-1:0] ADDR_MASK    = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } fetch_entry_t;

  // Instruction addresses are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ADDR_MASK;
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry buffer parking a fetched {pc, insn} while the decoder is stalled.
module if_hold_buf
  import if_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t entry,
  output logic         valid,
  output fetch_entry_t data
);

  // Clear wins over load so a redirect always kills a parked instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= entry;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC sequencing, redirect handling, memory request
// FSM and the IF/ID pipeline register.
module if_stage
  import if_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] new_pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_insn,
  output logic            if_en,
  output logic            if_busy
);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic            hold_load;
  logic            hold_clear;
  logic            hold_valid;
  fetch_entry_t    hold_entry;
  fetch_entry_t    hold_data;

  // Flush outranks a branch; both targets are forced to word alignment.
  always_comb begin
    redirect         = flush | br_taken;
    target           = word_align(flush ? new_pc : br_addr);
    seq_pc           = fetch_pc + PC_STEP;
    hold_load        = (state == ST_FETCH) && imem_ack && stall && !redirect;
    hold_clear       = redirect || ((state == ST_HOLD) && !stall);
    hold_entry.pc    = fetch_pc;
    hold_entry.insn  = imem_rdata;
  end

  if_hold_buf u_hold_buf (
    .clk   (clk),
    .reset (reset),
    .load  (hold_load),
    .clear (hold_clear),
    .entry (hold_entry),
    .valid (hold_valid),
    .data  (hold_data)
  );

  // imem_addr is its own register so a redirect never moves an outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FETCH;
      fetch_pc  <= RESET_VECTOR;
      imem_addr <= RESET_VECTOR;
      if_pc     <= '0;
      if_insn   <= NOP_INSN;
      if_en     <= 1'b0;
    end else begin
      unique case (state)
        ST_FETCH: begin
          if (redirect) begin
            fetch_pc <= target;
            if_en    <= 1'b0;
            if_insn  <= NOP_INSN;
            if (imem_ack) begin
              imem_addr <= target;
            end else begin
              state <= ST_DROP;
            end
          end else if (imem_ack) begin
            fetch_pc  <= seq_pc;
            imem_addr <= seq_pc;
            if (stall) begin
              state <= ST_HOLD;
            end else begin
              if_pc   <= fetch_pc;
              if_insn <= imem_rdata;
              if_en   <= 1'b1;
            end
          end else if (!stall) begin
            if_en <= 1'b0;
          end
        end

        ST_HOLD: begin
          if (redirect) begin
            fetch_pc  <= target;
            imem_addr <= target;
            if_en     <= 1'b0;
            if_insn   <= NOP_INSN;
            state     <= ST_FETCH;
          end else if (!stall) begin
            state <= ST_FETCH;
            if (hold_valid) begin
              if_pc   <= hold_data.pc;
              if_insn <= hold_data.insn;
              if_en   <= 1'b1;
            end
          end
        end

        ST_DROP: begin
          if (redirect) begin
            fetch_pc <= target;
            if_en    <= 1'b0;
            if_insn  <= NOP_INSN;
          end
          if (imem_ack) begin
            state     <= ST_FETCH;
            imem_addr <= redirect ? target : fetch_pc;
          end
        end

        default: state <= ST_FETCH;
      endcase
    end
  end

  assign imem_req = !reset && (state != ST_HOLD);
  assign if_busy  = ((state == ST_FETCH) && !imem_ack) || (state == ST_DROP);

  a_addr_aligned: assert property (@(posedge clk) disable iff (reset)
    imem_addr[1:0] == 2'b00);

  a_addr_stable: assert property (@(posedge clk) disable iff (reset)
    (imem_req && !imem_ack) |=> $stable(imem_addr));

  a_hold_full: assert property (@(posedge clk) disable iff (reset)
    (state == ST_HOLD) |-> hold_valid);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, reset-in-flight
// sequence, then random traffic against a transaction-level reference model.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned NROWS = 26;
  localparam int unsigned NRAND = 3000;

  logic        clk = 1'b0;
  logic        reset, stall, flush, br_taken, imem_ack;
  logic [31:0] new_pc, br_addr, imem_rdata;
  logic        imem_req, if_en, if_busy;
  logic [31:0] imem_addr, if_pc, if_insn;

  always #5 clk = ~clk;

  if_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .new_pc     (new_pc),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_pc      (if_pc),
    .if_insn    (if_insn),
    .if_en      (if_en),
    .if_busy    (if_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit model_on = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: program counter, a "stale" flag for an abandoned request
  // still on the bus, and a queue of parked instructions awaiting the decoder.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } ent_t;

  ent_t        m_park[$];
  ent_t        m_ent;
  bit          m_live  = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_req;
  logic [31:0] m_pc, m_addr, m_ipc, m_insn, m_tgt;
  logic        m_en;

  always @(posedge clk) begin
    if (reset) begin
      m_pc    = 32'h0;
      m_addr  = 32'h0;
      m_stale = 1'b0;
      m_park.delete();
      m_en    = 1'b0;
      m_ipc   = 32'h0;
      m_insn  = NOP;
      m_live  = 1'b1;
    end else if (m_live) begin
      m_req = (m_park.size() == 0);
      m_tgt = (flush ? new_pc : br_addr) & 32'hFFFF_FFFC;
      if (flush || br_taken) begin
        m_pc = m_tgt;
        m_park.delete();
        m_en   = 1'b0;
        m_insn = NOP;
        if (m_req && !imem_ack) begin
          m_stale = 1'b1;
        end else begin
          m_stale = 1'b0;
          m_addr  = m_tgt;
        end
      end else if (m_req && imem_ack) begin
        if (m_stale) begin
          m_stale = 1'b0;
          m_addr  = m_pc;
        end else begin
          if (stall) begin
            m_park.push_back('{m_pc, imem_rdata});
          end else begin
            m_en   = 1'b1;
            m_ipc  = m_pc;
            m_insn = imem_rdata;
          end
          m_pc   = m_pc + 32'd4;
          m_addr = m_pc;
        end
      end else if (m_park.size() != 0 && !stall) begin
        m_ent  = m_park.pop_front();
        m_en   = 1'b1;
        m_ipc  = m_ent.pc;
        m_insn = m_ent.insn;
      end else if (!stall) begin
        m_en = 1'b0;
      end
    end
  end

  task automatic check_model();
    chk("model_req",  32'(imem_req), 32'(!reset && m_park.size() == 0));
    chk("model_addr", imem_addr, m_addr);
    chk("model_en",   32'(if_en), 32'(m_en));
    chk("model_pc",   if_pc, m_ipc);
    chk("model_insn", if_insn, m_insn);
    chk("model_busy", 32'(if_busy), 32'(m_stale || (m_park.size() == 0 && !imem_ack)));
  endtask

  // Drive one cycle's inputs on the falling edge; memory returns addr^KEY.
  task automatic drive(input logic r, input logic s, input logic f, input logic b,
                       input logic [31:0] np, input logic [31:0] ba, input logic a);
    @(negedge clk);
    reset      = r;
    stall      = s;
    flush      = f;
    br_taken   = b;
    new_pc     = np;
    br_addr    = ba;
    imem_ack   = a;
    imem_rdata = a ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;
    #1;
    if (model_on) check_model();
  endtask

  typedef struct {
    logic        rst, stl, fl, br;
    logic [31:0] npc, baddr;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic        en;
    logic [31:0] pc, insn;
    logic        busy;
  } vec_t;

  function automatic vec_t v(input logic rst, input logic stl, input logic fl, input logic br,
                             input logic [31:0] npc, input logic [31:0] baddr, input logic ack,
                             input logic req, input logic [31:0] addr, input logic en,
                             input logic [31:0] pc, input logic [31:0] insn, input logic busy);
    vec_t t;
    t.rst = rst; t.stl = stl; t.fl = fl; t.br = br; t.npc = npc; t.baddr = baddr; t.ack = ack;
    t.req = req; t.addr = addr; t.en = en; t.pc = pc; t.insn = insn; t.busy = busy;
    return t;
  endfunction

  vec_t tbl[NROWS];
  logic r_rst, r_stl, r_fl, r_br, r_ack;
  logic [31:0] r_np, r_ba;

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; imem_ack = 1'b0;
    new_pc = 32'h0; br_addr = 32'h0; imem_rdata = 32'h0;

    //            rst stl fl br  new_pc        br_addr       ack  req addr          en pc            insn                    busy
    tbl[0]  = v(1, 0, 0, 0, 32'h0,        32'h0,        0,   0, 32'h0,        0, 32'h0,        NOP,                    1);
    tbl[1]  = v(0, 0, 0, 0, 32'h0,        32'h0,        1,   1, 32'h0,        0, 32'h0,        NOP,                    0);
    tbl[2]  = v(0, 0, 0, 0, 32'h0,        32'h0,        1,   1, 32'h4,        1, 32'h0,        32'h0 ^ KEY,            0);
    tbl[3]  = v(0, 0, 0, 0, 32'h0,        32'h0,        1,   1, 32'h8,        1, 32'h4,        32'h4 ^ KEY,            0);
    tbl[4]  = v(0, 0, 0, 0, 32'h0,        32'h0,        1,   1, 32'hC,        1, 32'h8,        32'h8 ^ KEY,            0);
    tbl[5]  = v(0, 1, 0, 0, 32'h0,        32'h0,        0,   1, 32'h10,       1, 32'hC,        32'hC ^ KEY,            1);
    tbl[6]  = v(0, 1, 0, 0, 32'h0,        32'h0,        1,   1, 32'h10,       1, 32'hC,        32'hC ^ KEY,            0);
    tbl[7]  = v(0, 1, 0, 0, 32'h0,        32'h0,        0,   0, 32'h14,       1, 32'hC,        32'hC ^ KEY,            0);
    tbl[8]  = v(0, 0, 0, 0, 32'h0,        32'h0,        0,   0, 32'h14,       1, 32'hC,        32'hC ^ KEY,            0);
    tbl[9]  = v(0, 0, 0, 0, 32'h0,        32'h0,        0,   1, 32'h14,       1, 32'h10,       32'h10 ^ KEY,           1);
    tbl[10] = v(0, 0, 0, 1, 32'h0,        32'h40,       1,   1, 32'h14,       0, 32'h10,       32'h10 ^ KEY,           0);
    tbl[11] = v(0, 0, 0, 0, 32'h0,        32'h0,        0,   1, 32'h40,       0, 32'h10,       NOP,                    1);
    tbl[12] = v(0, 0, 0, 1, 32'h0,        32'h200,      0,   1, 32'h40,       0, 32'h10,       NOP,                    1);
    tbl[13] = v(0, 0, 0, 0, 32'h0,        32'h0,        0,   1, 32'h40,       0, 32'h10,       NOP,                    1);
    tbl[14] = v(0, 0, 0, 0, 32'h0,        32'h0,        1,   1, 32'h40,       0, 32'h10,       NOP,                    1);
    tbl[15] = v(0, 0, 0, 0, 32'h0,        32'h0,        0,   1, 32'h200,      0, 32'h10,       NOP,                    1);
    tbl[16] = v(0, 0, 1, 1, 32'h100,      32'h200,      1,   1, 32'h200,      0, 32'h10,       NOP,                    0);
    tbl[17] = v(0, 0, 0, 0, 32'h0,        32'h0,        0,   1, 32'h100,      0, 32'h10,       NOP,                    1);
    tbl[18] = v(0, 0, 0, 1, 32'h0,        32'hFFFF_FFFC, 1,  1, 32'h100,      0, 32'h10,       NOP,                    0);
    tbl[19] = v(0, 0, 0, 0, 32'h0,        32'h0,        1,   1, 32'hFFFF_FFFC, 0, 32'h10,       NOP,                    0);
    tbl[20] = v(0, 0, 0, 0, 32'h0,        32'h0,        0,   1, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC ^ KEY,    1);
    tbl[21] = v(0, 0, 0, 1, 32'h0,        32'h300,      0,   1, 32'h0,        0, 32'hFFFF_FFFC, 32'hFFFF_FFFC ^ KEY,    1);
    tbl[22] = v(0, 0, 1, 0, 32'h400,      32'h0,        0,   1, 32'h0,        0, 32'hFFFF_FFFC, NOP,                    1);
    tbl[23] = v(0, 0, 0, 0, 32'h0,        32'h0,        1,   1, 32'h0,        0, 32'hFFFF_FFFC, NOP,                    1);
    tbl[24] = v(0, 0, 1, 0, 32'h503,      32'h0,        1,   1, 32'h400,      0, 32'hFFFF_FFFC, NOP,                    0);
    tbl[25] = v(0, 0, 0, 0, 32'h0,        32'h0,        0,   1, 32'h500,      0, 32'hFFFF_FFFC, NOP,                    1);

    drive(1, 0, 0, 0, 32'h0, 32'h0, 0);
    drive(1, 0, 0, 0, 32'h0, 32'h0, 0);
    model_on = 1'b1;

    for (int i = 0; i < int'(NROWS); i++) begin
      drive(tbl[i].rst, tbl[i].stl, tbl[i].fl, tbl[i].br, tbl[i].npc, tbl[i].baddr, tbl[i].ack);
      chk($sformatf("row%0d_req", i),  32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("row%0d_en", i),   32'(if_en), 32'(tbl[i].en));
      chk($sformatf("row%0d_pc", i),   if_pc, tbl[i].pc);
      chk($sformatf("row%0d_insn", i), if_insn, tbl[i].insn);
      chk($sformatf("row%0d_busy", i), 32'(if_busy), 32'(tbl[i].busy));
    end

    // Reset lands while a dropped request is still outstanding.
    drive(0, 0, 0, 1, 32'h0, 32'h600, 0);
    chk("rst_seq_busy_before", 32'(if_busy), 32'h1);
    drive(1, 0, 0, 0, 32'h0, 32'h0, 0);
    chk("rst_seq_req_in_reset", 32'(imem_req), 32'h0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 1);
    chk("rst_seq_req_after", 32'(imem_req), 32'h1);
    chk("rst_seq_addr_after", imem_addr, 32'h0);
    chk("rst_seq_en_after", 32'(if_en), 32'h0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0);
    chk("rst_seq_deliver_en", 32'(if_en), 32'h1);
    chk("rst_seq_deliver_pc", if_pc, 32'h0);
    chk("rst_seq_deliver_insn", if_insn, 32'h0 ^ KEY);
    chk("rst_seq_next_addr", imem_addr, 32'h4);

    for (int i = 0; i < int'(NRAND); i++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_stl = ($urandom_range(0, 99) < 30);
      r_fl  = ($urandom_range(0, 99) < 5);
      r_br  = ($urandom_range(0, 99) < 8);
      r_np  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : 32'($urandom);
      r_ba  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : 32'($urandom);
      r_ack = imem_req && ($urandom_range(0, 99) < 60);
      drive(r_rst, r_stl, r_fl, r_br, r_np, r_ba, r_ack);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- stall  in  1  IF stall from the main controller (load hazard)
- flush  in  1  IF flush from the main controller (exception or eret)
- new_pc  in  32  redirect target accompanying flush
- br_taken  in  1  branch redirect from EX
- br_addr  in  32  branch target
- imem_req  out  1  instruction memory request
- imem_addr  out  32  request address, word aligned
- imem_ack  in  1  response valid this cycle; may rise in the request cycle
- imem_rdata  in  32  instruction word, valid with imem_ack
- if_pc  out  32  IF/ID pipeline register PC
- if_insn  out  32  IF/ID pipeline register instruction
- if_en  out  1  IF/ID entry valid
- if_busy  out  1  fetch pending, nothing valid to deliver

Function
REQ-003 A 32-bit fetch_pc SHALL drive imem_addr; bits [1:0] SHALL always be 0.
REQ-004 Redirect priority SHALL be flush (new_pc), then br_taken (br_addr), then sequential fetch_pc+4, wrapping modulo 2^32 with no carry out.
REQ-005 The FSM SHALL have three states:
- FETCH: imem_req=1.
- HOLD: hold buffer full; imem_req=0.
- DROP: imem_req=1, response discarded.
REQ-006 imem_addr SHALL stay stable from request until ack; a redirect SHALL never change the address of an outstanding request.
REQ-007 In FETCH with ack and no stall, the block SHALL load if_pc=fetch_pc, if_insn=imem_rdata, if_en=1 next cycle and set fetch_pc+=4 (latency 1 cycle from ack).
REQ-008 In FETCH with ack and stall, the block SHALL capture {pc, insn} into a 1-entry hold buffer, keep the IF/ID register unchanged, and go to HOLD.
REQ-009 In HOLD, on the first cycle with stall=0, the buffer SHALL move into IF/ID with if_en=1, and the FSM SHALL return to FETCH and request fetch_pc next cycle.
REQ-010 While stall=1 with no ack, if_pc/if_insn/if_en SHALL hold their values.
REQ-011 When flush or br_taken is high and imem_req=1 without ack, the block SHALL set fetch_pc to the target and enter DROP; DROP SHALL discard the ack data and then go to FETCH at the target.
REQ-012 When a redirect coincides with ack, or occurs while no request is outstanding, the data SHALL be discarded and FETCH SHALL start at the target next cycle, with no DROP.
REQ-013 Any redirect SHALL invalidate the hold buffer and load if_en=0 and if_insn=NOP (32'h0000_0013) next cycle.
REQ-014 Flush and br_taken in the same cycle SHALL redirect to new_pc.
REQ-015 If a redirect arrives while in DROP, fetch_pc SHALL update to the newer target and the block SHALL remain in DROP.
REQ-016 if_busy SHALL equal (state==FETCH && !imem_ack) || state==DROP.

Reset
REQ-017 On reset the block SHALL set fetch_pc=RESET_VECTOR (32'h0000_0000), state=FETCH, hold buffer invalid, if_pc=0, if_insn=NOP, if_en=0.
REQ-018 imem_req SHALL be 0 during the reset cycle and 1 on the first cycle after reset.
REQ-019 Reset during an outstanding request SHALL abandon the request without entering DROP, and an ack in the first post-reset cycle SHALL count as the response to the new request.

Structure
REQ-020 RESET_VECTOR, the NOP encoding, the FSM state encoding and the 32-bit bus widths SHALL live in the shared core defines package.
REQ-021 The block SHALL contain one sub-module, if_hold_buf (1-entry valid/pc/insn register); the FSM and PC logic SHALL be in if_stage.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then ack every cycle with rdata=addr^32'hA5A5_0000 -> if_pc sequence 0,4,8 on consecutive cycles, if_en=1 from cycle 2.
- Stall for 3 cycles while ack arrives for 0x10 -> IF/ID holds 0x0C; imem_req=0 for 2 cycles; 0x10 delivered the cycle after stall falls.
- br_taken to 0x200 while the request for 0x40 awaits ack (ack 2 cycles later) -> DROP, 0x40 data never on if_insn, next imem_addr=0x200, if_en=0 in between.
- flush new_pc=0x100 and br_taken br_addr=0x200 in the same cycle -> next imem_addr=0x100.
- fetch_pc=0xFFFF_FFFC with ack -> next imem_addr=0x0000_0000.
- Reset asserted mid-request, ack in the first post-reset cycle -> data taken as address 0x0, if_en=0 during reset.
